mux_sweep_ctrl: RTL and testbench
=================================

Name: mux_sweep_ctrl

Overview:
- Hardware self-check sequencer for the 2:1 select datapath z = (c & b) | (a & ~c).
- Replaces the per-vector plusargs bench flow.
- On a start request it drives all 8 {a,b,c} combinations onto the datapath in ascending order and waits a programmable settle time per vector.
- Samples z and compares it against the golden value (c ? b : a), then reports pass/fail, the failure count and the first failing vector.

Parameters:
- SETTLE, 1, cycles each vector is held before z is sampled; legal range 1..15.
- CNT_W, 4, width of fail_cnt; minimum 4.

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  run request, sampled only in IDLE
- abort  input  1  cancel run, sampled in WAIT/CHECK
- z  input  1  datapath output under test
- a_o  output  1  datapath input a
- b_o  output  1  datapath input b
- c_o  output  1  datapath select c
- busy  output  1  high in WAIT and CHECK
- done  output  1  one-cycle pulse at end of a complete sweep
- pass  output  1  1 when the last completed sweep had zero failures
- fail_cnt  output  CNT_W  mismatches in the current or last sweep
- first_fail_vec  output  3  {a,b,c} of the first mismatch
- first_fail_valid  output  1  first_fail_vec holds a captured mismatch

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - all outputs 0, state IDLE, idx=0, settle counter 0.
  - Reset mid-sweep aborts immediately, with no done pulse.
- idx is a 3-bit vector index. {a_o,b_o,c_o} = idx; all three are registered outputs.
- Golden value: exp = c_o ? b_o : a_o, computed from the registered outputs.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - a_o/b_o/c_o = 0.
  - start=1 and abort=0 → WAIT. At the same edge: idx<=0, settle counter<=SETTLE-1, fail_cnt<=0, pass<=0, first_fail_valid<=0, first_fail_vec<=0.
  - start=1 with abort=1: stay in IDLE; abort wins.
- WAIT:
  - Counter reaches 0 → CHECK; otherwise decrement.
  - The vector is held for exactly SETTLE cycles.
- CHECK (1 cycle): sample z.
  - If z !== exp: fail_cnt increments, saturating at 2^CNT_W-1.
  - If z !== exp and first_fail_valid=0: capture first_fail_vec<=idx and set first_fail_valid<=1.
  - idx==7 → DONE.
  - Otherwise idx<=idx+1, counter<=SETTLE-1, next state WAIT.
- DONE (1 cycle):
  - done=1.
  - pass<=(fail_cnt==0), where fail_cnt includes the final CHECK's update.
  - Next state IDLE; a_o/b_o/c_o return to 0.
- Timing: the start edge is edge 0. DONE is entered at edge 8*(SETTLE+1). With SETTLE=1, done is high in the cycle after edge 16.
- abort=1 in WAIT or CHECK:
  - next edge → IDLE; the CHECK sample of that cycle is discarded.
  - No done pulse; pass stays 0.
  - fail_cnt, first_fail_* keep their partial values until the next start.
- start while busy or in DONE: ignored; it does not queue.
- pass, fail_cnt and first_fail_* hold their values in IDLE until the next accepted start.
- z is treated as asynchronous datapath output; no synchronizer. SETTLE covers propagation.

Test Plan:
- Correct datapath model, SETTLE=1, start pulse → vectors 000..111 at 2-cycle spacing; done high 16 cycles after start; pass=1, fail_cnt=0, first_fail_valid=0.
- z stuck at 0 → fail_cnt=4 (vectors 011,100,110,111); first_fail_vec=3'b011; pass=0; done still at cycle 16.
- z = ~golden → fail_cnt=8, first_fail_vec=3'b000, pass=0. Then correct model with a second start → pass=1, fail_cnt=0 (results cleared on start).
- SETTLE=3 with a model whose z lags inputs by 2 cycles → pass=1, done at cycle 32. Same model with SETTLE=1 → pass=0, fail_cnt>0.
- abort asserted during vector idx=4 → IDLE next edge, busy=0, no done pulse, a/b/c=000, pass=0. start+abort in the same IDLE cycle → stays IDLE.
- rst_n low mid-sweep (idx=5) → all outputs 0 immediately, with no clock edge needed. After release, start → full 8-vector sweep from 000.

Source files
------------

// File: rtl/mux_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_sweep_ctrl
// Purpose  : Self-check sequencer for the 2:1 select datapath
//            z = (c & b) | (a & ~c). On start it walks {a,b,c} through
//            000..111, holds each vector for SETTLE cycles, then samples z
//            against the golden value (c ? b : a) and accumulates results.
// Ports    : clk, rst_n          - clock, async active-low reset
//            start, abort        - run request (IDLE only), cancel (busy only)
//            z                   - datapath output under test
//            a_o, b_o, c_o       - registered datapath stimulus
//            busy, done          - WAIT/CHECK indicator, end-of-sweep pulse
//            pass, fail_cnt      - sweep verdict and mismatch count
//            first_fail_vec/_valid - {a,b,c} of the first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module mux_sweep_ctrl #(
   parameter int SETTLE = 1,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             z,
   output logic             a_o,
   output logic             b_o,
   output logic             c_o,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [2:0]       first_fail_vec,
   output logic             first_fail_valid
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0]       C_SETTLE_M1 = 4'(SETTLE - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic [3:0] r_cnt;
   logic [2:0] r_idx;
   logic       w_exp;
   logic       w_mis;
   logic       w_accept;

   // Stimulus bits are the vector index itself, so they are registered.
   assign {a_o, b_o, c_o} = r_idx;
   assign w_exp           = c_o ? b_o : a_o;
   assign w_mis           = z ^ w_exp;
   assign w_accept        = start & ~abort;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_WAIT;
         S_WAIT: begin
            if (abort)              w_next = S_IDLE;
            else if (r_cnt == 4'd0) w_next = S_CHECK;
         end
         S_CHECK: begin
            if (abort)              w_next = S_IDLE;
            else if (r_idx == 3'd7) w_next = S_DONE;
            else                    w_next = S_WAIT;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_WAIT, S_CHECK: busy = 1'b1;
         S_DONE:          done = 1'b1;
         default:         ;
      endcase
   end

   // ---------------- sweep datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx            <= 3'd0;
         r_cnt            <= 4'd0;
         pass             <= 1'b0;
         fail_cnt         <= '0;
         first_fail_vec   <= 3'd0;
         first_fail_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_idx            <= 3'd0;
                  r_cnt            <= C_SETTLE_M1;
                  fail_cnt         <= '0;
                  pass             <= 1'b0;
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= 3'd0;
               end
            end
            S_WAIT: begin
               if (abort) begin
                  r_idx <= 3'd0;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_CHECK: begin
               // An abort discards this cycle's sample entirely.
               if (abort) begin
                  r_idx <= 3'd0;
               end else begin
                  if (w_mis) begin
                     if (fail_cnt != '1) fail_cnt <= fail_cnt + C_CNT_ONE;
                     if (!first_fail_valid) begin
                        first_fail_vec   <= r_idx;
                        first_fail_valid <= 1'b1;
                     end
                  end
                  if (r_idx != 3'd7) begin
                     r_idx <= r_idx + 3'd1;
                     r_cnt <= C_SETTLE_M1;
                  end
               end
            end
            S_DONE: begin
               // fail_cnt already includes the last CHECK here.
               pass  <= (fail_cnt == '0);
               r_idx <= 3'd0;
            end
            default: r_idx <= 3'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sweep_ctrl
// Purpose  : Self-checking bench for mux_sweep_ctrl. Two instances
//            (SETTLE=1 and SETTLE=3) drive behavioural datapath models:
//            correct, stuck-at-0, inverted, 2-cycle lag and random faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sweep_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       st     [2];
   logic       ab     [2];
   logic       zz     [2];
   logic       a_w    [2];
   logic       b_w    [2];
   logic       c_w    [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic       pass_w [2];
   logic [3:0] fc_w   [2];
   logic [2:0] ffv_w  [2];
   logic       ffok_w [2];
   logic [2:0] abc_w  [2];
   logic [2:0] d1     [2];
   logic [2:0] d2     [2];
   int         mode   [2];
   logic [7:0] mask   [2];

   int n_checks = 0;
   int n_err    = 0;

   mux_sweep_ctrl #(.SETTLE(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .z(zz[0]),
      .a_o(a_w[0]), .b_o(b_w[0]), .c_o(c_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .pass(pass_w[0]), .fail_cnt(fc_w[0]),
      .first_fail_vec(ffv_w[0]), .first_fail_valid(ffok_w[0]));

   mux_sweep_ctrl #(.SETTLE(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .z(zz[1]),
      .a_o(a_w[1]), .b_o(b_w[1]), .c_o(c_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .pass(pass_w[1]), .fail_cnt(fc_w[1]),
      .first_fail_vec(ffv_w[1]), .first_fail_valid(ffok_w[1]));

   assign abc_w[0] = {a_w[0], b_w[0], c_w[0]};
   assign abc_w[1] = {a_w[1], b_w[1], c_w[1]};

   // Golden select: v = {a,b,c}
   function automatic logic gold(input logic [2:0] v);
      return v[0] ? v[1] : v[2];
   endfunction

   // Steady-state datapath behaviour for the non-lagging models.
   function automatic logic zsteady(input int m, input logic [7:0] msk, input logic [2:0] v);
      case (m)
         1:       return 1'b0;
         2:       return ~gold(v);
         4:       return gold(v) ^ msk[v];
         default: return gold(v);
      endcase
   endfunction

   // Lag model: z follows the inputs two clock edges late.
   always @(posedge clk) begin
      d1[0] <= abc_w[0]; d2[0] <= d1[0];
      d1[1] <= abc_w[1]; d2[1] <= d1[1];
   end

   assign zz[0] = (mode[0] == 3) ? gold(d2[0]) : zsteady(mode[0], mask[0], abc_w[0]);
   assign zz[1] = (mode[1] == 3) ? gold(d2[1]) : zsteady(mode[1], mask[1], abc_w[1]);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int settle_of(input int d);
      return (d == 1) ? 3 : 1;
   endfunction

   // Compares result registers against the model over the first nv vectors.
   task automatic chk_results(input int d, input int nv, input string tag);
      int       cnt;
      bit       fv;
      int       ff;
      cnt = 0; fv = 0; ff = 0;
      for (int v = 0; v < nv; v++) begin
         if (zsteady(mode[d], mask[d], 3'(v)) != gold(3'(v))) begin
            cnt++;
            if (!fv) begin fv = 1; ff = v; end
         end
      end
      chk({tag, "_fail_cnt"}, 32'(fc_w[d]), 32'(cnt));
      chk({tag, "_ffvalid"},  32'(ffok_w[d]), 32'(fv));
      chk({tag, "_ffvec"},    32'(ffv_w[d]), 32'(ff));
      chk({tag, "_pass"},     32'(pass_w[d]), 32'((nv == 8) && (cnt == 0)));
   endtask

   task automatic chk_outs_zero(input int d, input string tag);
      chk({tag, "_abc"},  32'(abc_w[d]), 32'd0);
      chk({tag, "_busy"}, 32'(busy_w[d]), 32'd0);
      chk({tag, "_done"}, 32'(done_w[d]), 32'd0);
      chk({tag, "_pass"}, 32'(pass_w[d]), 32'd0);
      chk({tag, "_fc"},   32'(fc_w[d]), 32'd0);
      chk({tag, "_ffv"},  32'(ffv_w[d]), 32'd0);
      chk({tag, "_ffok"}, 32'(ffok_w[d]), 32'd0);
   endtask

   // Entered and left 1 time unit after a rising edge.
   // abort_at < 0: full sweep; otherwise abort raised after that edge.
   // poke: extra start pulses while busy and while in DONE.
   task automatic run_sweep(input int d, input int abort_at, input bit poke);
      int  s;
      int  tot;
      bit  late_done;
      s   = settle_of(d);
      tot = 8 * (s + 1);
      st[d] = 1'b1;
      @(posedge clk); #1;
      st[d] = 1'b0;
      chk("start_busy", 32'(busy_w[d]), 32'd1);
      chk("start_abc",  32'(abc_w[d]), 32'd0);
      for (int n = 1; n <= tot; n++) begin
         if (abort_at >= 0 && n - 1 == abort_at) ab[d] = 1'b1;
         if (poke && n == 5) st[d] = 1'b1;
         @(posedge clk); #1;
         ab[d] = 1'b0;
         st[d] = 1'b0;
         if (abort_at >= 0 && n == abort_at + 1) begin
            chk("abort_busy", 32'(busy_w[d]), 32'd0);
            chk("abort_done", 32'(done_w[d]), 32'd0);
            chk("abort_abc",  32'(abc_w[d]), 32'd0);
            chk_results(d, abort_at / (s + 1), "abort");
            late_done = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               late_done |= done_w[d];
            end
            chk("abort_no_done", 32'(late_done), 32'd0);
            return;
         end
         if (n < tot) begin
            if (abc_w[d] != 3'(n / (s + 1)) || !busy_w[d] || done_w[d])
               chk("sweep_seq", {abc_w[d], busy_w[d], done_w[d]}, {3'(n / (s + 1)), 2'b10});
         end else begin
            chk("done_pulse", 32'(done_w[d]), 32'd1);
            chk("done_abc",   32'(abc_w[d]), 32'd7);
            chk("done_busy",  32'(busy_w[d]), 32'd0);
         end
      end
      if (poke) st[d] = 1'b1;
      @(posedge clk); #1;
      st[d] = 1'b0;
      chk("post_done", 32'(done_w[d]), 32'd0);
      chk("post_busy", 32'(busy_w[d]), 32'd0);
      chk("post_abc",  32'(abc_w[d]), 32'd0);
      if (mode[d] == 3 && s < 2) begin
         chk("lag_fails", 32'(fc_w[d] != 4'd0), 32'd1);
         chk("lag_pass",  32'(pass_w[d]), 32'd0);
      end else begin
         chk_results(d, 8, "sweep");
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         st[i] = 1'b0; ab[i] = 1'b0; mode[i] = 0; mask[i] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      chk_outs_zero(0, "reset");
      chk_outs_zero(1, "reset3");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Correct datapath, with ignored starts during busy and DONE.
      mode[0] = 0; run_sweep(0, -1, 1'b1);
      // Stuck-at-0: fails on 011,100,110,111.
      mode[0] = 1; run_sweep(0, -1, 1'b0);
      // Inverted, then correct: results cleared on start.
      mode[0] = 2; run_sweep(0, -1, 1'b0);
      mode[0] = 0; run_sweep(0, -1, 1'b0);
      // Lagging datapath: enough settle at SETTLE=3, too little at 1.
      mode[1] = 3; run_sweep(1, -1, 1'b0);
      mode[0] = 3; run_sweep(0, -1, 1'b0);

      // Abort during vector 4.
      mode[0] = 1; run_sweep(0, 8, 1'b0);
      // start and abort together in IDLE.
      st[0] = 1'b1; ab[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0; ab[0] = 1'b0;
      chk("start_abort_idle", 32'(busy_w[0]), 32'd0);

      // Asynchronous reset in the middle of vector 5.
      mode[0] = 1;
      st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_reset_abc", 32'(abc_w[0]), 32'd5);
      rst_n = 1'b0;
      #2;
      chk_outs_zero(0, "async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mode[0] = 0; run_sweep(0, -1, 1'b0);

      // Random fault masks, random abort points.
      for (int r = 0; r < 8; r++) begin
         int d;
         int abt;
         d       = int'($urandom_range(0, 1));
         mode[d] = 4;
         mask[d] = 8'($urandom);
         if ($urandom_range(0, 1) == 1)
            abt = int'($urandom_range(0, 8 * (settle_of(d) + 1) - 1));
         else
            abt = -1;
         run_sweep(d, abt, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
